// File: rtl/h2c_marker_ctrl.sv
// H2C marker sequencer: one MM or ST marker request per command, then waits
// for the matching response and reports done/timeout/latency.
module h2c_marker_ctrl #(
  parameter int unsigned TO_W    = 16,
  parameter int unsigned TIMEOUT = 16'hFFFF
) (
  input  logic            axi_aclk,
  input  logic            axi_aresetn,
  input  logic            cmd_vld,
  input  logic            cmd_st_mm,
  output logic            cmd_rdy,
  output logic            h2c_mm_marker_req,
  output logic            h2c_st_marker_req,
  input  logic            h2c_byp_in_mm_rdy,
  input  logic            h2c_byp_in_st_rdy,
  input  logic            h2c_mm_marker_rsp,
  input  logic            h2c_st_marker_rsp,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [TO_W-1:0] last_latency,
  output logic            stray_rsp
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_RSP,
    FIN
  } state_e;

  localparam logic [TO_W-1:0] CNT_MAX = '1;
  localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e          state_q, state_d;
  logic            sel_mm_q, sel_mm_d;
  logic [TO_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic            cmd_rdy_q, cmd_rdy_d;
  logic            mm_req_q, mm_req_d;
  logic            st_req_q, st_req_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            to_q, to_d;
  logic [TO_W-1:0] lat_q, lat_d;
  logic            stray_q, stray_d;
  logic            rsp_sel, rdy_sel, to_hit, stray_hit;

  always_comb begin
    rsp_sel = sel_mm_q ? h2c_mm_marker_rsp : h2c_st_marker_rsp;
    rdy_sel = sel_mm_q ? h2c_byp_in_mm_rdy : h2c_byp_in_st_rdy;
    to_hit  = (cnt_q == TO_LAST);
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
    // Only the selected response while waiting is expected; all else is stray.
    if (state_q == WAIT_RSP) begin
      stray_hit = sel_mm_q ? h2c_st_marker_rsp : h2c_mm_marker_rsp;
    end else begin
      stray_hit = h2c_mm_marker_rsp | h2c_st_marker_rsp;
    end
  end

  always_comb begin
    state_d  = state_q;
    sel_mm_d = sel_mm_q;
    cnt_d    = cnt_q;
    mm_req_d = 1'b0;
    st_req_d = 1'b0;
    done_d   = 1'b0;
    to_d     = 1'b0;
    lat_d    = lat_q;
    stray_d  = stray_q | stray_hit;
    unique case (state_q)
      IDLE: begin
        if (cmd_vld && cmd_rdy_q) begin
          state_d  = REQ;
          sel_mm_d = cmd_st_mm;
          cnt_d    = '0;
          mm_req_d = cmd_st_mm;
          st_req_d = ~cmd_st_mm;
        end
      end
      REQ: begin
        cnt_d = cnt_inc;
        if (to_hit) begin
          state_d = FIN;
          to_d    = 1'b1;
        end else if (rdy_sel) begin
          state_d = WAIT_RSP;
        end else begin
          mm_req_d = sel_mm_q;
          st_req_d = ~sel_mm_q;
        end
      end
      WAIT_RSP: begin
        cnt_d = cnt_inc;
        if (rsp_sel) begin
          state_d = FIN;
          done_d  = 1'b1;
          lat_d   = cnt_q + CNT_ONE;
        end else if (to_hit) begin
          state_d = FIN;
          to_d    = 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    cmd_rdy_d = (state_d == IDLE);
    busy_d    = (state_d != IDLE);
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q   <= IDLE;
      sel_mm_q  <= 1'b0;
      cnt_q     <= '0;
      cmd_rdy_q <= 1'b0;
      mm_req_q  <= 1'b0;
      st_req_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      to_q      <= 1'b0;
      lat_q     <= '0;
      stray_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_mm_q  <= sel_mm_d;
      cnt_q     <= cnt_d;
      cmd_rdy_q <= cmd_rdy_d;
      mm_req_q  <= mm_req_d;
      st_req_q  <= st_req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      to_q      <= to_d;
      lat_q     <= lat_d;
      stray_q   <= stray_d;
    end
  end

  assign cmd_rdy           = cmd_rdy_q;
  assign h2c_mm_marker_req = mm_req_q;
  assign h2c_st_marker_req = st_req_q;
  assign busy              = busy_q;
  assign done              = done_q;
  assign timeout           = to_q;
  assign last_latency      = lat_q;
  assign stray_rsp         = stray_q;

endmodule

// File: tb/tb_h2c_marker_ctrl.sv
// Scoreboard bench for h2c_marker_ctrl: expected request beats and
// completion events are queued by stimulus and checked by a monitor.
module tb_h2c_marker_ctrl;

  localparam int TO_W = 16;
  localparam int TMO  = 20;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            cmd_vld, cmd_st_mm, cmd_rdy;
  logic            mm_req, st_req;
  logic            mm_rdy, st_rdy, mm_rsp, st_rsp;
  logic            busy, done, timeout, stray;
  logic [TO_W-1:0] last_lat;

  h2c_marker_ctrl #(.TO_W(TO_W), .TIMEOUT(TMO)) dut (
    .axi_aclk          (clk),
    .axi_aresetn       (rst_n),
    .cmd_vld           (cmd_vld),
    .cmd_st_mm         (cmd_st_mm),
    .cmd_rdy           (cmd_rdy),
    .h2c_mm_marker_req (mm_req),
    .h2c_st_marker_req (st_req),
    .h2c_byp_in_mm_rdy (mm_rdy),
    .h2c_byp_in_st_rdy (st_rdy),
    .h2c_mm_marker_rsp (mm_rsp),
    .h2c_st_marker_rsp (st_rsp),
    .busy              (busy),
    .done              (done),
    .timeout           (timeout),
    .last_latency      (last_lat),
    .stray_rsp         (stray)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit to;
    int lat;
    int cyc;
  } ev_t;

  typedef struct {
    bit mm;
    int len;
  } req_t;

  ev_t  evq[$];
  req_t reqq[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   t0      = 0;
  int   run     = 0;
  bit   run_mm  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: request beat runs and completion events against the queues.
  always @(negedge clk) begin
    if (mm_req && st_req) check("req_exclusive", 1, 0);
    if (mm_req || st_req) begin
      if (run > 0 && run_mm != mm_req) check("req_path_stable", int'(mm_req), int'(run_mm));
      run_mm = mm_req;
      run++;
    end else if (run > 0) begin
      if (reqq.size() == 0) begin
        check("req_unexpected", run, 0);
      end else begin
        req_t r;
        r = reqq.pop_front();
        check("req_path", int'(run_mm), int'(r.mm));
        check("req_len", run, r.len);
      end
      run = 0;
    end
    if (done || timeout) begin
      check("done_and_timeout", int'(done && timeout), 0);
      if (evq.size() == 0) begin
        check("event_unexpected", 1, 0);
      end else begin
        ev_t e;
        e = evq.pop_front();
        check("event_kind_timeout", int'(timeout), int'(e.to));
        check("event_cycle", cyc, e.cyc);
        if (done) check("event_latency", int'(last_lat), e.lat);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic mm);
    int n;
    n = 0;
    while (!cmd_rdy && n < 50) begin
      tick();
      n++;
    end
    if (!cmd_rdy) check("cmd_rdy_wait", 0, 1);
    cmd_st_mm = mm;
    cmd_vld   = 1'b1;
    tick();
    cmd_vld = 1'b0;
    t0      = cyc;
  endtask

  task automatic expect_ev(input bit to, input int lat, input int dly);
    ev_t e;
    e.to  = to;
    e.lat = lat;
    e.cyc = t0 + dly;
    evq.push_back(e);
  endtask

  task automatic expect_req(input bit mm, input int len);
    req_t r;
    r.mm  = mm;
    r.len = len;
    reqq.push_back(r);
  endtask

  task automatic pulse_st();
    st_rsp = 1'b1;
    tick();
    st_rsp = 1'b0;
  endtask

  task automatic pulse_mm();
    mm_rsp = 1'b1;
    tick();
    mm_rsp = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {cmd_vld, cmd_st_mm, mm_rdy, st_rdy, mm_rsp, st_rsp} = '0;
    tick();
    tick();
    check("rst_cmd_rdy", int'(cmd_rdy), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_lat", int'(last_lat), 0);
    check("rst_stray", int'(stray), 0);
    rst_n = 1'b1;
    check("rel_cmd_rdy_0", int'(cmd_rdy), 0);
    tick();
    check("rel_cmd_rdy_1", int'(cmd_rdy), 1);

    // Stray in IDLE, wrong-path response and ignored command while busy
    pulse_st();
    tick();
    check("stray_idle", int'(stray), 1);
    st_rdy = 1'b1;
    issue(1'b0);
    expect_req(1'b0, 1);
    expect_ev(1'b0, 8, 8);
    cmd_vld   = 1'b1;
    cmd_st_mm = 1'b1;
    tick();
    tick();
    pulse_mm();
    cmd_vld = 1'b0;
    repeat (4) tick();
    pulse_st();
    repeat (4) tick();
    check("stray_sticky", int'(stray), 1);
    check("stray_lat", int'(last_lat), 8);

    // ST basic
    issue(1'b0);
    expect_req(1'b0, 1);
    expect_ev(1'b0, 6, 6);
    repeat (5) tick();
    pulse_st();
    repeat (3) tick();
    check("st_lat", int'(last_lat), 6);
    st_rdy = 1'b0;

    // MM with backpressure
    mm_rdy = 1'b0;
    issue(1'b1);
    expect_req(1'b1, 11);
    expect_ev(1'b0, 14, 14);
    repeat (10) tick();
    mm_rdy = 1'b1;
    tick();
    repeat (2) tick();
    pulse_mm();
    repeat (3) tick();
    check("mm_lat", int'(last_lat), 14);

    // Timeout with no response
    issue(1'b1);
    expect_req(1'b1, 1);
    expect_ev(1'b1, 0, TMO);
    repeat (TMO) tick();
    check("to_pulse", int'(timeout), 1);
    check("to_no_done", int'(done), 0);
    check("to_cmd_rdy_fin", int'(cmd_rdy), 0);
    tick();
    check("to_cmd_rdy_idle", int'(cmd_rdy), 1);
    check("to_lat_kept", int'(last_lat), 14);
    mm_rdy = 1'b0;

    // Response in the last cycle before timeout
    st_rdy = 1'b1;
    issue(1'b0);
    expect_req(1'b0, 1);
    expect_ev(1'b0, TMO, TMO);
    repeat (TMO - 1) tick();
    pulse_st();
    check("race_timeout", int'(timeout), 0);
    repeat (3) tick();
    check("race_lat", int'(last_lat), TMO);

    // Reset while waiting for a response
    issue(1'b0);
    expect_req(1'b0, 1);
    repeat (3) tick();
    check("mid_busy", int'(busy), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("ar_busy", int'(busy), 0);
    check("ar_reqs", int'(mm_req | st_req), 0);
    check("ar_done_to", int'(done | timeout), 0);
    check("ar_cmd_rdy", int'(cmd_rdy), 0);
    check("ar_lat", int'(last_lat), 0);
    check("ar_stray", int'(stray), 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("ar_idle", int'(cmd_rdy), 1);
    pulse_st();
    repeat (3) tick();
    check("ar_inflight_stray", int'(stray), 1);
    check("ar_busy_after", int'(busy), 0);

    repeat (3) tick();
    check("evq_empty", evq.size(), 0);
    check("reqq_empty", reqq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
